// File: rtl/asteroid_pkg.sv
// Shared types and constants for the asteroid field: slot state, slot record and the spawn LFSR.
package asteroid_pkg;

    localparam int unsigned SCREEN_CORDW = 16;
    localparam int unsigned EXPL_W       = 8;
    localparam int unsigned LFSR_W       = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h12D8;

    typedef enum logic [1:0] {AST_IDLE, AST_FALLING, AST_EXPLODING} ast_state_t;

    typedef struct packed {
        ast_state_t                     st;
        logic signed [SCREEN_CORDW-1:0] x;
        logic signed [SCREEN_CORDW-1:0] y;
        logic [EXPL_W-1:0]              ecnt;
    } slot_t;

    // One step of the 16-bit Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/asteroid_slot.sv
// One asteroid slot: state, position and explosion timer, plus beam/shot containment flags.
module asteroid_slot
    import asteroid_pkg::*;
#(
    parameter int unsigned V_RES          = 480,
    parameter int unsigned AST_SIZE       = 40,
    parameter int unsigned EXPLODE_FRAMES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame,
    input  logic                            spawn,
    input  logic        [SCREEN_CORDW-1:0]  spawn_x,
    input  logic        [7:0]               speed,
    input  logic                            hit,
    input  logic signed [SCREEN_CORDW-1:0]  beam_x,
    input  logic signed [SCREEN_CORDW-1:0]  beam_y,
    input  logic signed [SCREEN_CORDW-1:0]  shot_x,
    input  logic signed [SCREEN_CORDW-1:0]  shot_y,
    output ast_state_t                      st,
    output logic                            beam_in_c,
    output logic                            shot_in_c,
    output logic                            escape_c
);

    localparam int unsigned CW = SCREEN_CORDW;
    localparam logic signed [CW-1:0] SIZE   = CW'(AST_SIZE);
    localparam logic signed [CW-1:0] BOTTOM = CW'(V_RES);
    localparam logic [EXPL_W-1:0]    EXPL_LAST = EXPL_W'(EXPLODE_FRAMES - 1);

    slot_t s;
    logic signed [CW-1:0] sx;
    logic signed [CW-1:0] sy;
    logic signed [CW-1:0] ny;

    // Half-open square box test against the slot's current position.
    function automatic logic in_box(input logic signed [CW-1:0] px, input logic signed [CW-1:0] py,
                                    input logic signed [CW-1:0] bx, input logic signed [CW-1:0] by);
        return (px >= bx) && (px < bx + SIZE) && (py >= by) && (py < by + SIZE);
    endfunction

    assign sx        = s.x;
    assign sy        = s.y;
    assign ny        = sy + $signed(CW'(speed));
    assign st        = s.st;
    assign beam_in_c = (s.st != AST_IDLE) && in_box(beam_x, beam_y, sx, sy);
    assign shot_in_c = (s.st == AST_FALLING) && in_box(shot_x, shot_y, sx, sy);
    // A hit in the same cycle takes precedence over leaving the screen.
    assign escape_c  = frame && (s.st == AST_FALLING) && !hit && (ny >= BOTTOM);

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            case (s.st)
                AST_IDLE: begin
                    if (spawn) begin
                        s.st <= AST_FALLING;
                        s.x  <= spawn_x;
                        s.y  <= -SIZE;
                    end
                end
                AST_FALLING: begin
                    if (hit) begin
                        s.st   <= AST_EXPLODING;
                        s.ecnt <= '0;
                    end else if (frame) begin
                        if (escape_c) s.st <= AST_IDLE;
                        else          s.y  <= ny;
                    end
                end
                AST_EXPLODING: begin
                    if (frame) begin
                        if (s.ecnt == EXPL_LAST) s.st   <= AST_IDLE;
                        else                     s.ecnt <= s.ecnt + EXPL_W'(1);
                    end
                end
                default: s.st <= AST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/asteroid_field.sv
// Asteroid pool: spawn timing/LFSR, hit/draw priority and registered outputs.
// Optional ASTEROID_FIELD_SPEED_RAMP_EN adds escape-count driven speed-up.
module asteroid_field
    import asteroid_pkg::*;
#(
    parameter int unsigned N_SLOTS        = 8,
    parameter int unsigned H_RES          = 640,
    parameter int unsigned V_RES          = 480,
    parameter int unsigned COLR_BITS      = 4,
    parameter int unsigned AST_SIZE       = 40,
    parameter int unsigned SPAWN_INTERVAL = 32,
    parameter int unsigned EXPLODE_FRAMES = 8,
    parameter logic [COLR_BITS-1:0] COLR_ROCK = COLR_BITS'(4'h7),
    parameter logic [COLR_BITS-1:0] COLR_BOOM = COLR_BITS'(4'hE),
    localparam int unsigned ID_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int unsigned CNT_W = $clog2(N_SLOTS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame,
    input  logic                            run,
    input  logic        [7:0]               speed,
    input  logic                            shot_valid,
    input  logic signed [SCREEN_CORDW-1:0]  shot_x,
    input  logic signed [SCREEN_CORDW-1:0]  shot_y,
    input  logic signed [SCREEN_CORDW-1:0]  screen_x,
    input  logic signed [SCREEN_CORDW-1:0]  screen_y,
    output logic                            hit_valid,
    output logic        [ID_W-1:0]          hit_id,
    output logic                            escaped,
    output logic        [CNT_W-1:0]         active_cnt,
    output logic                            drawing,
    output logic        [COLR_BITS-1:0]     pixel
);

    localparam int unsigned SPC_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [SPC_W-1:0]  SPC_LAST = SPC_W'(SPAWN_INTERVAL - 1);
    localparam logic [LFSR_W-1:0] X_RANGE  = LFSR_W'(H_RES - AST_SIZE);

    logic [SPC_W-1:0]        spawn_cnt;
    logic [LFSR_W-1:0]       lfsr;
    logic [7:0]              speed_eff;
    logic [SCREEN_CORDW-1:0] spawn_x;
    ast_state_t              st [N_SLOTS];
    logic [N_SLOTS-1:0]      beam_in, shot_in, esc, spawn_sel, hit_sel;
    logic                    any_idle, any_hit, any_beam, beam_boom, spawn_now;
    logic [ID_W-1:0]         hit_idx;
    logic [CNT_W-1:0]        busy_cnt;

    assign spawn_x   = SCREEN_CORDW'(lfsr % X_RANGE);
    assign spawn_now = frame && run && (spawn_cnt == SPC_LAST) && any_idle;

`ifdef ASTEROID_FIELD_SPEED_RAMP_EN
    logic [7:0] esc_total;
    logic [8:0] ramp_sum;

    always_ff @(posedge clk) begin
        if (rst)                             esc_total <= '0;
        else if (|esc && esc_total != 8'hFF) esc_total <= esc_total + 8'd1;
    end

    assign ramp_sum  = {1'b0, speed} + {3'b000, esc_total[7:2]};
    assign speed_eff = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];
`else
    assign speed_eff = speed;
`endif

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        asteroid_slot #(
            .V_RES          (V_RES),
            .AST_SIZE       (AST_SIZE),
            .EXPLODE_FRAMES (EXPLODE_FRAMES)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .frame     (frame),
            .spawn     (spawn_now && spawn_sel[g]),
            .spawn_x   (spawn_x),
            .speed     (speed_eff),
            .hit       (shot_valid && hit_sel[g]),
            .beam_x    (screen_x),
            .beam_y    (screen_y),
            .shot_x    (shot_x),
            .shot_y    (shot_y),
            .st        (st[g]),
            .beam_in_c (beam_in[g]),
            .shot_in_c (shot_in[g]),
            .escape_c  (esc[g])
        );
    end

    // Lowest-index priority for spawn target, shot target and drawn slot.
    always_comb begin
        spawn_sel = '0;
        hit_sel   = '0;
        hit_idx   = '0;
        any_idle  = 1'b0;
        any_hit   = 1'b0;
        any_beam  = 1'b0;
        beam_boom = 1'b0;
        busy_cnt  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (st[i] == AST_IDLE && !any_idle) begin
                any_idle     = 1'b1;
                spawn_sel[i] = 1'b1;
            end
            if (shot_in[i] && !any_hit) begin
                any_hit    = 1'b1;
                hit_sel[i] = 1'b1;
                hit_idx    = ID_W'(i);
            end
            if (beam_in[i] && !any_beam) begin
                any_beam  = 1'b1;
                beam_boom = (st[i] == AST_EXPLODING);
            end
            if (st[i] != AST_IDLE) busy_cnt = busy_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_cnt  <= '0;
            lfsr       <= LFSR_SEED;
            hit_valid  <= 1'b0;
            hit_id     <= '0;
            escaped    <= 1'b0;
            active_cnt <= '0;
            drawing    <= 1'b0;
            pixel      <= '0;
        end else begin
            if (frame) begin
                lfsr <= lfsr_next(lfsr);
                // Counter saturates and holds while the pool is full or spawning is paused.
                if (spawn_now)                  spawn_cnt <= '0;
                else if (spawn_cnt != SPC_LAST) spawn_cnt <= spawn_cnt + SPC_W'(1);
            end
            hit_valid <= shot_valid && any_hit;
            if (shot_valid && any_hit) hit_id <= hit_idx;
            escaped    <= |esc;
            active_cnt <= busy_cnt;
            drawing    <= any_beam;
            pixel      <= !any_beam ? '0 : (beam_boom ? COLR_BOOM : COLR_ROCK);
        end
    end

endmodule

// File: tb/tb_asteroid_field.sv
// Directed bench for asteroid_field: an 8-slot instance for the main scenarios, a 2-slot one for pool saturation.
module tb_asteroid_field;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, frame, run, shot_valid;
    logic        [7:0]  speed;
    logic signed [15:0] shot_x, shot_y, screen_x, screen_y;
    logic               hit_valid, escaped, drawing;
    logic        [2:0]  hit_id;
    logic        [3:0]  active_cnt, pixel;

    logic               rst2, frame2, run2, shot2_valid;
    logic        [7:0]  speed2;
    logic               hit_valid2, escaped2, drawing2;
    logic        [0:0]  hit_id2;
    logic        [1:0]  active_cnt2;
    logic        [3:0]  pixel2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] lfsr_m;
    int x0, x1, x2, s0x, s1x, px, junk;

    asteroid_field dut (
        .clk(clk), .rst(rst), .frame(frame), .run(run), .speed(speed),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .screen_x(screen_x), .screen_y(screen_y),
        .hit_valid(hit_valid), .hit_id(hit_id), .escaped(escaped),
        .active_cnt(active_cnt), .drawing(drawing), .pixel(pixel)
    );

    asteroid_field #(.N_SLOTS(2)) dut2 (
        .clk(clk), .rst(rst2), .frame(frame2), .run(run2), .speed(speed2),
        .shot_valid(shot2_valid), .shot_x(shot_x), .shot_y(shot_y),
        .screen_x(screen_x), .screen_y(screen_y),
        .hit_valid(hit_valid2), .hit_id(hit_id2), .escaped(escaped2),
        .active_cnt(active_cnt2), .drawing(drawing2), .pixel(pixel2)
    );

    function automatic logic [15:0] adv(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        lfsr_m = adv(lfsr_m);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic set_beam(input int x, input int y);
        screen_x = 16'(x);
        screen_y = 16'(y);
        tick();
        tick();
    endtask

    function automatic int cur_x();
        return int'(lfsr_m % 16'd600);
    endfunction

    // Let the spawn counter saturate with run=0, then release run on the first frame whose x suits 'kind'.
    task automatic spawn_pick(input int kind, output int x, output logic ok);
        run = 1'b0;
        frames(31);
        ok = 1'b0;
        x  = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            x = cur_x();
            case (kind)
                0:       ok = 1'b1;
                1:       ok = !((x + 20 >= s0x) && (x + 20 < s0x + 40));
                2:       ok = !((px >= x) && (px < x + 40));
                default: ok = (x >= s1x - 19) && (x <= s1x + 19);
            endcase
            if (ok) run = 1'b1;
            do_frame();
            run = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; frame = 1'b0; frame2 = 1'b0; run = 1'b0; run2 = 1'b0;
        speed = 8'd0; speed2 = 8'd0; shot_valid = 1'b0; shot2_valid = 1'b0;
        shot_x = '0; shot_y = '0; screen_x = '0; screen_y = '0;
        tick();
        tick();
        n_tests++; if (hit_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_hit_valid: got %0b want 0", hit_valid); end
        n_tests++; if (escaped !== 1'b0)     begin n_fail++; $display("FAIL reset_escaped: got %0b want 0", escaped); end
        n_tests++; if (active_cnt !== 4'd0)  begin n_fail++; $display("FAIL reset_active_cnt: got %0d want 0", active_cnt); end
        n_tests++; if (drawing !== 1'b0)     begin n_fail++; $display("FAIL reset_drawing: got %0b want 0", drawing); end
        n_tests++; if (pixel !== 4'h0)       begin n_fail++; $display("FAIL reset_pixel: got %h want 0", pixel); end
        n_tests++; if (active_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_active_cnt2: got %0d want 0", active_cnt2); end
        rst = 1'b0; rst2 = 1'b0;
        lfsr_m = 16'h12D8;
    endtask

    task automatic test_pool_full();
        int esc_seen;
        esc_seen = 0;
        speed2 = 8'd8;
        run2   = 1'b1;
        for (int f = 1; f <= 200; f++) begin
            frame2 = 1'b1;
            tick();
            frame2 = 1'b0;
            if (escaped2 === 1'b1) esc_seen++;
            n_tests++; if (active_cnt2 > 2'd2) begin n_fail++; $display("FAIL pool_cap f=%0d: active_cnt2=%0d want <=2", f, active_cnt2); end
            if (f == 96) begin
                n_tests++; if (active_cnt2 !== 2'd2) begin n_fail++; $display("FAIL pool_full_f96: active_cnt2=%0d want 2", active_cnt2); end
            end
        end
        tick();
        n_tests++; if (esc_seen != 4)        begin n_fail++; $display("FAIL pool_escapes: got %0d want 4", esc_seen); end
        n_tests++; if (active_cnt2 !== 2'd2) begin n_fail++; $display("FAIL pool_end_active: got %0d want 2", active_cnt2); end
        run2 = 1'b0;
    endtask

    task automatic test_spawn();
        run = 1'b1;
        speed = 8'd4;
        frames(31);
        tick();
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL spawn_early: active_cnt=%0d want 0", active_cnt); end
        x0 = cur_x();
        do_frame();
        tick();
        n_tests++; if (active_cnt !== 4'd1) begin n_fail++; $display("FAIL spawn_f32: active_cnt=%0d want 1", active_cnt); end
        set_beam(x0, -40);
        n_tests++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL spawn_top_draw: drawing=%0b want 1", drawing); end
        n_tests++; if (pixel !== 4'h7)   begin n_fail++; $display("FAIL spawn_top_pixel: pixel=%h want 7", pixel); end
        set_beam(x0, -41);
        n_tests++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL spawn_above: drawing=%0b want 0", drawing); end
        n_tests++; if (pixel !== 4'h0)   begin n_fail++; $display("FAIL spawn_above_pixel: pixel=%h want 0", pixel); end
        frames(10);
        set_beam(x0, -1);
        n_tests++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL move_above: drawing=%0b want 0", drawing); end
        set_beam(x0, 0);
        n_tests++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL move_top: drawing=%0b want 1", drawing); end
        set_beam(x0 + 39, 39);
        n_tests++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL move_corner: drawing=%0b want 1", drawing); end
        set_beam(x0 + 40, 0);
        n_tests++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL move_right_edge: drawing=%0b want 0", drawing); end
    endtask

    task automatic test_hit();
        shot_x = 16'(x0 + 40); shot_y = 16'sd0; shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        n_tests++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL hit_edge_miss: hit_valid=%0b want 0", hit_valid); end
        shot_x = 16'(x0 + 39); shot_y = 16'sd39; shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        n_tests++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL hit_corner: hit_valid=%0b want 1", hit_valid); end
        n_tests++; if (hit_id !== 3'd0)    begin n_fail++; $display("FAIL hit_corner_id: hit_id=%0d want 0", hit_id); end
        tick();
        n_tests++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_width: hit_valid=%0b want 0", hit_valid); end
        set_beam(x0, 0);
        n_tests++; if (pixel !== 4'hE) begin n_fail++; $display("FAIL hit_boom_pixel: pixel=%h want e", pixel); end
        frames(7);
        tick();
        n_tests++; if (active_cnt !== 4'd1) begin n_fail++; $display("FAIL explode_7: active_cnt=%0d want 1", active_cnt); end
        do_frame();
        tick();
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL explode_8: active_cnt=%0d want 0", active_cnt); end
        set_beam(x0, 0);
        n_tests++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL explode_gone: drawing=%0b want 0", drawing); end
    endtask

    task automatic test_escape();
        speed = 8'd255;
        frames(13);
        x1 = cur_x();
        do_frame();
        tick();
        n_tests++; if (active_cnt !== 4'd1) begin n_fail++; $display("FAIL esc_spawn: active_cnt=%0d want 1", active_cnt); end
        do_frame();
        n_tests++; if (escaped !== 1'b0) begin n_fail++; $display("FAIL esc_y215: escaped=%0b want 0", escaped); end
        do_frame();
        n_tests++; if (escaped !== 1'b0) begin n_fail++; $display("FAIL esc_y470: escaped=%0b want 0", escaped); end
        set_beam(x1, 479);
        n_tests++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL esc_draw_470: drawing=%0b want 1", drawing); end
        do_frame();
        n_tests++; if (escaped !== 1'b1) begin n_fail++; $display("FAIL esc_pulse: escaped=%0b want 1", escaped); end
        tick();
        n_tests++; if (escaped !== 1'b0)    begin n_fail++; $display("FAIL esc_pulse_end: escaped=%0b want 0", escaped); end
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL esc_idle: active_cnt=%0d want 0", active_cnt); end
        frames(28);
        x2 = cur_x();
        do_frame();
        frames(2);
        shot_x = 16'(x2 + 1); shot_y = 16'sd471; shot_valid = 1'b1; frame = 1'b1;
        tick();
        shot_valid = 1'b0; frame = 1'b0;
        lfsr_m = adv(lfsr_m);
        n_tests++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL hitesc_hit: hit_valid=%0b want 1", hit_valid); end
        n_tests++; if (hit_id !== 3'd0)    begin n_fail++; $display("FAIL hitesc_id: hit_id=%0d want 0", hit_id); end
        n_tests++; if (escaped !== 1'b0)   begin n_fail++; $display("FAIL hitesc_no_escape: escaped=%0b want 0", escaped); end
        tick();
        n_tests++; if (escaped !== 1'b0)   begin n_fail++; $display("FAIL hitesc_no_late_escape: escaped=%0b want 0", escaped); end
        frames(8);
        tick();
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL hitesc_cleared: active_cnt=%0d want 0", active_cnt); end
    endtask

    task automatic test_overlap();
        logic ok0, ok1, ok2, ok3;
        speed = 8'd0;
        spawn_pick(0, s0x, ok0);
        spawn_pick(1, s1x, ok1);
        px = s1x + 20;
        spawn_pick(2, junk, ok2);
        spawn_pick(3, junk, ok3);
        n_tests++; if (!(ok0 && ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL overlap_setup: picks %0b%0b%0b%0b want 1111", ok0, ok1, ok2, ok3); end
        tick();
        n_tests++; if (active_cnt !== 4'd4) begin n_fail++; $display("FAIL overlap_active: active_cnt=%0d want 4", active_cnt); end
        set_beam(px, -20);
        n_tests++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL overlap_draw: drawing=%0b want 1", drawing); end
        n_tests++; if (pixel !== 4'h7)   begin n_fail++; $display("FAIL overlap_rock: pixel=%h want 7", pixel); end
        shot_x = 16'(px); shot_y = -16'sd20; shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        n_tests++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL overlap_hit: hit_valid=%0b want 1", hit_valid); end
        n_tests++; if (hit_id !== 3'd1)    begin n_fail++; $display("FAIL overlap_hit_id: hit_id=%0d want 1", hit_id); end
        set_beam(px, -20);
        n_tests++; if (pixel !== 4'hE) begin n_fail++; $display("FAIL overlap_boom: pixel=%h want e", pixel); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        shot_x = 16'(px); shot_y = -16'sd20; shot_valid = 1'b1;
        tick();
        n_tests++; if (hit_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_hit_valid: got %0b want 0", hit_valid); end
        n_tests++; if (escaped !== 1'b0)    begin n_fail++; $display("FAIL rstmid_escaped: got %0b want 0", escaped); end
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_active_cnt: got %0d want 0", active_cnt); end
        n_tests++; if (drawing !== 1'b0)    begin n_fail++; $display("FAIL rstmid_drawing: got %0b want 0", drawing); end
        n_tests++; if (pixel !== 4'h0)      begin n_fail++; $display("FAIL rstmid_pixel: got %h want 0", pixel); end
        rst = 1'b0;
        lfsr_m = 16'h12D8;
        tick();
        n_tests++; if (hit_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_shot_after: hit_valid=%0b want 0", hit_valid); end
        shot_valid = 1'b0;
        tick();
        n_tests++; if (drawing !== 1'b0)    begin n_fail++; $display("FAIL rstmid_idle_draw: drawing=%0b want 0", drawing); end
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_idle_cnt: active_cnt=%0d want 0", active_cnt); end
    endtask

    initial begin
        test_reset();
        test_pool_full();
        test_spawn();
        test_hit();
        test_escape();
        test_overlap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: bench did not complete, %0d tests run so far", n_tests);
        $fatal(1);
    end

endmodule
